div_norm_ctrl: RTL

Pre-processing sequencer for the radix-16 integer divider. It accepts an operand pair and forms absolute values. It then time-shares a single leading-zero counter (WIDTH bits, MODE=1) over two cycles: divisor first, then dividend. It produces the leading-zero counts, the zero/early-finish flags and the radix-16 iteration count consumed by the divider iteration FSM.

---
 rtl/div_norm_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/div_norm_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// div_norm_ctrl : operand abs/leading-zero pre-processing for the radix-16 divider
// Revision 1.0 : initial release
// ============================================================================

module div_norm_lzc #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     data_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);
    // An all-zero input reports WIDTH-1 so the divider sees a 1-bit operand.
    always_comb begin
        cnt_o   = CNT_WIDTH'(WIDTH - 1);
        empty_o = (data_i == '0);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end
endmodule

module div_norm_ctrl #(
    parameter int WIDTH      = 64,
    parameter int CNT_WIDTH  = $clog2(WIDTH),
    parameter int ITER_WIDTH = $clog2(WIDTH / 4) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic                  signed_op_i,
    input  logic [WIDTH-1:0]      dividend_i,
    input  logic [WIDTH-1:0]      divisor_i,
    output logic                  finish_valid_o,
    input  logic                  finish_ready_i,
    output logic [WIDTH-1:0]      dividend_abs_o,
    output logic [WIDTH-1:0]      divisor_abs_o,
    output logic [CNT_WIDTH-1:0]  dividend_lzc_o,
    output logic [CNT_WIDTH-1:0]  divisor_lzc_o,
    output logic                  divisor_is_zero_o,
    output logic                  early_finish_o,
    output logic [ITER_WIDTH-1:0] iter_num_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CNT_DVSR = 2'd1,
        CNT_DVND = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      dividend_abs_q, dividend_abs_d;
    logic [WIDTH-1:0]      divisor_abs_q, divisor_abs_d;
    logic [CNT_WIDTH-1:0]  dividend_lzc_q, dividend_lzc_d;
    logic [CNT_WIDTH-1:0]  divisor_lzc_q, divisor_lzc_d;
    logic                  divisor_is_zero_q, divisor_is_zero_d;
    logic                  early_finish_q, early_finish_d;
    logic [ITER_WIDTH-1:0] iter_num_q, iter_num_d;

    logic [WIDTH-1:0]      lzc_in;
    logic [CNT_WIDTH-1:0]  lzc_cnt;
    logic                  lzc_empty;
    logic                  dvnd_zero;
    logic [CNT_WIDTH-1:0]  lzc_diff;

    div_norm_lzc #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lzc (
        .data_i  (lzc_in),
        .cnt_o   (lzc_cnt),
        .empty_o (lzc_empty)
    );

    always_comb begin
        state_d           = state_q;
        dividend_abs_d    = dividend_abs_q;
        divisor_abs_d     = divisor_abs_q;
        dividend_lzc_d    = dividend_lzc_q;
        divisor_lzc_d     = divisor_lzc_q;
        divisor_is_zero_d = divisor_is_zero_q;
        early_finish_d    = early_finish_q;
        iter_num_d        = iter_num_q;
        start_ready_o     = (state_q == IDLE) && !flush_i;
        finish_valid_o    = (state_q == DONE);
        dvnd_zero         = lzc_empty;
        lzc_diff          = divisor_lzc_q - lzc_cnt;

        case (state_q)
            CNT_DVSR: lzc_in = divisor_abs_q;
            CNT_DVND: lzc_in = dividend_abs_q;
            default:  lzc_in = '0;
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid_i) begin
                        // The most negative value negates to itself and is read as unsigned.
                        dividend_abs_d = (signed_op_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
                        divisor_abs_d  = (signed_op_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
                        state_d        = CNT_DVSR;
                    end
                end
                CNT_DVSR: begin
                    divisor_lzc_d     = lzc_cnt;
                    divisor_is_zero_d = lzc_empty;
                    state_d           = CNT_DVND;
                end
                CNT_DVND: begin
                    dividend_lzc_d = lzc_cnt;
                    // Equal counts with dividend < divisor still iterate once.
                    early_finish_d = !divisor_is_zero_q && (dvnd_zero || (lzc_cnt > divisor_lzc_q));
                    if (divisor_is_zero_q || early_finish_d) begin
                        iter_num_d = '0;
                    end else begin
                        iter_num_d = ITER_WIDTH'(lzc_diff >> 2) + ITER_WIDTH'(1);
                    end
                    state_d = DONE;
                end
                DONE: begin
                    if (finish_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            dividend_abs_q    <= '0;
            divisor_abs_q     <= '0;
            dividend_lzc_q    <= '0;
            divisor_lzc_q     <= '0;
            divisor_is_zero_q <= 1'b0;
            early_finish_q    <= 1'b0;
            iter_num_q        <= '0;
        end else begin
            state_q           <= state_d;
            dividend_abs_q    <= dividend_abs_d;
            divisor_abs_q     <= divisor_abs_d;
            dividend_lzc_q    <= dividend_lzc_d;
            divisor_lzc_q     <= divisor_lzc_d;
            divisor_is_zero_q <= divisor_is_zero_d;
            early_finish_q    <= early_finish_d;
            iter_num_q        <= iter_num_d;
        end
    end

    assign dividend_abs_o    = dividend_abs_q;
    assign divisor_abs_o     = divisor_abs_q;
    assign dividend_lzc_o    = dividend_lzc_q;
    assign divisor_lzc_o     = divisor_lzc_q;
    assign divisor_is_zero_o = divisor_is_zero_q;
    assign early_finish_o    = early_finish_q;
    assign iter_num_o        = iter_num_q;

endmodule

`default_nettype wire
